// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, flag positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_XOR   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Bit positions inside flags = {N, Z, C, V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between an ALU client and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  import alu_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, illegal
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per clock.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic             busy_reg;
  logic             is_div_reg;
  logic             sel_hi_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] opnd_reg;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // hi/lo hold {product high, product low} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    rem_shift = {hi_reg, lo_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_reg};
    q_bit     = ~rem_diff[WIDTH];
    if (is_div_reg) begin
      hi_next = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], q_bit};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  // The final step's outcome is offered directly so the caller can latch it on that same edge.
  assign done   = busy_reg && (count_reg == LAST_STEP);
  assign result = sel_hi_reg ? hi_next : lo_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg   <= 1'b0;
      is_div_reg <= 1'b0;
      sel_hi_reg <= 1'b0;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      is_div_reg <= is_div;
      sel_hi_reg <= sel_hi;
      count_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= is_div ? a : b;
      opnd_reg   <= is_div ? b : a;
    end else if (busy_reg) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
      if (count_reg == LAST_STEP) begin
        busy_reg  <= 1'b0;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative mul/div, valid/ready on both sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  state_e           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [3:0]       flags_reg;
  logic             illegal_reg;

  logic             accept;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [3:0]       md_flags;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic             add_ovf;
  logic             slt_v;
  logic             sltu_v;
  logic [WIDTH-1:0] sc_result_next;
  logic [3:0]       sc_flags_next;
  logic             sc_illegal_next;

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;
  assign bus.illegal   = illegal_reg;

  assign accept   = bus.in_valid && (state_reg == ST_IDLE);
  assign md_start = accept && is_multi(bus.op);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_v[gi] = bus.a[gi] & bus.b[gi];
      assign or_v[gi]  = bus.a[gi] | bus.b[gi];
      assign xor_v[gi] = bus.a[gi] ^ bus.b[gi];
    end
  endgenerate

  always_comb begin
    is_sub   = (bus.op == OP_SUB);
    b_eff    = is_sub ? ~bus.b : bus.b;
    add_full = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    add_ovf  = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != bus.a[WIDTH-1]);
    // Direct signed compare stays correct where the sign of A-B would be fooled by overflow.
    slt_v    = $signed(bus.a) < $signed(bus.b);
    sltu_v   = bus.a < bus.b;

    sc_result_next  = '0;
    sc_illegal_next = 1'b0;
    sc_flags_next   = 4'b0000;
    case (bus.op)
      OP_AND:  sc_result_next = and_v;
      OP_OR:   sc_result_next = or_v;
      OP_XOR:  sc_result_next = xor_v;
      OP_ADD,
      OP_SUB: begin
        sc_result_next        = add_full[WIDTH-1:0];
        sc_flags_next[FLAG_C] = add_full[WIDTH];
        sc_flags_next[FLAG_V] = add_ovf;
      end
      OP_SLT:  sc_result_next = {{(WIDTH-1){1'b0}}, slt_v};
      OP_SLTU: sc_result_next = {{(WIDTH-1){1'b0}}, sltu_v};
      default: sc_illegal_next = 1'b1;
    endcase
    sc_flags_next[FLAG_N] = sc_result_next[WIDTH-1];
    sc_flags_next[FLAG_Z] = (sc_result_next == '0);
  end

  always_comb begin
    md_flags         = 4'b0000;
    md_flags[FLAG_N] = md_result[WIDTH-1];
    md_flags[FLAG_Z] = (md_result == '0);
  end

  alu_seq_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div ((bus.op == OP_DIVU) || (bus.op == OP_REMU)),
    .sel_hi ((bus.op == OP_MULHU) || (bus.op == OP_REMU)),
    .a      (bus.a),
    .b      (bus.b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      flags_reg   <= 4'b0000;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (is_multi(bus.op)) begin
              state_reg <= ST_BUSY;
            end else begin
              state_reg   <= ST_DONE;
              result_reg  <= sc_result_next;
              flags_reg   <= sc_flags_next;
              illegal_reg <= sc_illegal_next;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state_reg   <= ST_DONE;
            result_reg  <= md_result;
            flags_reg   <= md_flags;
            illegal_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
